// File: rtl/proj_sorter_drain.sv
// Captures the sorter's top-K index array on request and streams it out one
// index per beat, smallest signature first, over a valid/ready handshake.
package proj_pkg;
  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int INDICE_LEN = 8;
endpackage

module proj_sorter_drain #(
  parameter  int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
  parameter  int INDICE_LEN    = proj_pkg::INDICE_LEN,
  localparam int CNT_W         = $clog2(INDICES_COUNT + 1),
  localparam int POS_W         = $clog2(INDICES_COUNT)
) (
  input  logic                                     in_clk,
  input  logic                                     in_rst_n,
  input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_smallest_idx,
  input  logic [CNT_W-1:0]                         in_count,
  input  logic                                     in_snapshot,
  output logic [INDICE_LEN-1:0]                    out_idx,
  output logic [POS_W-1:0]                         out_pos,
  output logic                                     out_valid,
  input  logic                                     in_ready,
  output logic                                     out_last,
  output logic                                     out_busy,
  output logic                                     out_done,
  output logic                                     out_overrun
);

  // state | meaning
  // IDLE  | waiting for a snapshot request; captures on in_snapshot
  // SEND  | streaming the captured entries, pos = current beat
  typedef enum logic {IDLE, SEND} state_t;

  state_t                                   state, state_nxt;
  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] snap, snap_nxt;
  logic [CNT_W-1:0]                         cnt, cnt_nxt, count_clamped;
  logic [POS_W-1:0]                         pos, pos_nxt;
  logic                                     done, done_nxt;
  logic                                     overrun, overrun_nxt;
  logic                                     last, xfer;

  assign count_clamped = (in_count > CNT_W'(INDICES_COUNT)) ? CNT_W'(INDICES_COUNT) : in_count;
  // cnt is at least 1 whenever SEND is active, so cnt-1 never wraps there
  assign last = (CNT_W'(pos) == (cnt - CNT_W'(1)));
  assign xfer = (state == SEND) && in_ready;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state   <= IDLE;
      snap    <= '0;
      cnt     <= '0;
      pos     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      snap    <= snap_nxt;
      cnt     <= cnt_nxt;
      pos     <= pos_nxt;
      done    <= done_nxt;
      overrun <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    snap_nxt    = snap;
    cnt_nxt     = cnt;
    pos_nxt     = pos;
    done_nxt    = 1'b0;
    overrun_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (in_snapshot) begin
          snap_nxt = in_smallest_idx;
          cnt_nxt  = count_clamped;
          pos_nxt  = '0;
          if (count_clamped == '0) done_nxt  = 1'b1;
          else                     state_nxt = SEND;
        end
      end
      SEND: begin
        overrun_nxt = in_snapshot;
        if (xfer) begin
          if (last) begin
            state_nxt = IDLE;
            pos_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            pos_nxt = pos + POS_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid   = (state == SEND);
  assign out_busy    = (state == SEND);
  assign out_idx     = out_valid ? snap[pos] : '0;
  assign out_pos     = out_valid ? pos : '0;
  assign out_last    = out_valid && last;
  assign out_done    = done;
  assign out_overrun = overrun;

endmodule

// File: tb/tb_proj_sorter_drain.sv
// Scoreboard bench for proj_sorter_drain: stimulus queues expected beats and
// pulse cycles, a negedge monitor pops and compares them.
module tb_proj_sorter_drain;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int CNT_W = 3;
  localparam int POS_W = 2;

  logic                 in_clk = 1'b0;
  logic                 in_rst_n = 1'b0;
  logic [N-1:0][W-1:0]  in_smallest_idx;
  logic [CNT_W-1:0]     in_count = '0;
  logic                 in_snapshot = 1'b0;
  logic                 in_ready = 1'b1;
  logic [W-1:0]         out_idx;
  logic [POS_W-1:0]     out_pos;
  logic                 out_valid, out_last, out_busy, out_done, out_overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [W-1:0]     idx;
    logic [POS_W-1:0] pos;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    done_q[$];
  int    ovr_q[$];
  logic [W-1:0] base_arr [N] = '{8'h11, 8'h22, 8'h33, 8'h44};

  proj_sorter_drain dut (
    .in_clk          (in_clk),
    .in_rst_n        (in_rst_n),
    .in_smallest_idx (in_smallest_idx),
    .in_count        (in_count),
    .in_snapshot     (in_snapshot),
    .out_idx         (out_idx),
    .out_pos         (out_pos),
    .out_valid       (out_valid),
    .in_ready        (in_ready),
    .out_last        (out_last),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_overrun     (out_overrun)
  );

  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic load_base();
    for (int i = 0; i < N; i++) in_smallest_idx[i] = base_arr[i];
  endtask

  // returns the first cycle after the sampling edge
  task automatic snap(input logic [CNT_W-1:0] c, output int s);
    in_count    = c;
    in_snapshot = 1'b1;
    step();
    in_snapshot = 1'b0;
    s = cyc;
  endtask

  task automatic push_stream(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.idx  = base_arr[i];
      b.pos  = POS_W'(i);
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  always @(negedge in_clk) begin
    int req;
    if (out_valid) begin
      if (exp_q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
      else begin
        check("beat_idx", 32'(out_idx), 32'(exp_q[0].idx));
        check("beat_pos", 32'(out_pos), 32'(exp_q[0].pos));
        check("beat_last", 32'(out_last), 32'(exp_q[0].last));
        if (in_ready) void'(exp_q.pop_front());
      end
    end else begin
      check("idle_outputs_zero", {out_idx, out_pos, out_last}, 32'd0);
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      req = done_q.pop_front();
      check("missed_done", 32'(cyc), 32'(req));
    end
    if (out_done) begin
      if (done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        req = done_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(req));
      end
    end
    while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
      req = ovr_q.pop_front();
      check("missed_overrun", 32'(cyc), 32'(req));
    end
    if (out_overrun) begin
      if (ovr_q.size() == 0) check("unexpected_overrun", 32'd1, 32'd0);
      else begin
        req = ovr_q.pop_front();
        check("overrun_cycle", 32'(cyc), 32'(req));
      end
    end
  end

  initial begin
    int  s, s2;
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    load_base();
    #3;
    check("reset_outputs", {out_valid, out_idx, out_pos, out_last, out_busy, out_done, out_overrun}, 32'd0);
    step();
    step();
    #2 in_rst_n = 1'b1;

    // full stream, ready held high
    snap(3'd4, s);
    push_stream(4);
    done_q.push_back(s + 4);
    check("busy_first_beat", 32'(out_busy), 32'd1);
    repeat (3) step();
    check("busy_last_beat", 32'(out_busy), 32'd1);
    step();
    check("busy_after_stream", 32'(out_busy), 32'd0);
    step();

    // stalls: transfers at s, s+3, s+4, s+6
    snap(3'd4, s);
    push_stream(4);
    done_q.push_back(s + 7);
    in_ready = pat[0];
    for (int k = 1; k < 7; k++) begin
      step();
      in_ready = pat[k];
    end
    step();
    in_ready = 1'b1;
    step();

    // count 2, count 0, count 7 (clamped)
    snap(3'd2, s);
    push_stream(2);
    done_q.push_back(s + 2);
    repeat (3) step();
    snap(3'd0, s);
    done_q.push_back(s);
    check("busy_count0", 32'(out_busy), 32'd0);
    step();
    snap(3'd7, s);
    push_stream(4);
    done_q.push_back(s + 4);
    repeat (5) step();

    // request while streaming: ignored, array change has no effect
    snap(3'd4, s);
    push_stream(4);
    done_q.push_back(s + 4);
    step();
    for (int i = 0; i < N; i++) in_smallest_idx[i] = 8'hAA + W'(i * 17);
    in_count    = 3'd3;
    in_snapshot = 1'b1;
    ovr_q.push_back(s + 2);
    step();
    in_snapshot = 1'b0;
    repeat (3) step();
    load_base();

    // request on last-transfer cycle (overrun), then in the done cycle (accepted)
    snap(3'd2, s);
    push_stream(2);
    done_q.push_back(s + 2);
    step();
    in_snapshot = 1'b1;
    ovr_q.push_back(s + 2);
    step();
    in_count = 3'd3;
    push_stream(3);
    done_q.push_back(s + 6);
    step();
    in_snapshot = 1'b0;
    s2 = cyc;
    check("accept_in_done_cycle", 32'(out_busy), 32'd1);
    check("restart_cycle", 32'(s2), 32'(s + 3));
    repeat (4) step();

    // reset mid-stream after two beats
    snap(3'd4, s);
    push_stream(4);
    done_q.push_back(s + 4);
    step();
    step();
    #2 in_rst_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    check("reset_drops_valid", 32'(out_valid), 32'd0);
    check("reset_drops_busy", 32'(out_busy), 32'd0);
    step();
    step();
    #2 in_rst_n = 1'b1;
    snap(3'd3, s);
    push_stream(3);
    done_q.push_back(s + 3);
    check("post_reset_pos", 32'(out_pos), 32'd0);
    repeat (4) step();

    for (int k = 0; k < 20 && (exp_q.size() + done_q.size() + ovr_q.size()) != 0; k++) step();
    check("pending_beats", 32'(exp_q.size()), 32'd0);
    check("pending_done", 32'(done_q.size()), 32'd0);
    check("pending_overrun", 32'(ovr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proj_sorter_drain.md
# proj_sorter_drain

Reads out the top-K index list produced by the MinHash sorter. On a snapshot request it captures the sorter's parallel array of smallest-signature indices plus a valid-entry count. It then streams the indices one per beat, smallest signature first, over a valid/ready interface toward the extender/output stage. While draining, the sorter is free to start accumulating the next batch.

## Interface
- INDICES_COUNT, proj_pkg::SORTER_EXTENDER_INDICES_COUNT, number of entries in the sorter array (≥2)
- INDICE_LEN, proj_pkg::INDICE_LEN, width of one index
- CNT_W, $clog2(INDICES_COUNT+1), width of count ports (derived, not overridden)
- POS_W, $clog2(INDICES_COUNT), width of position output (derived)

Ports:
- in_clk  input  1  clock; one clock domain
- in_rst_n  input  1  asynchronous, active-low reset
- in_smallest_idx  input  [INDICES_COUNT-1:0][INDICE_LEN-1:0]  sorter array; entry 0 = smallest signature
- in_count  input  CNT_W  number of valid entries in the array
- in_snapshot  input  1  capture request, sampled on the clock edge
- out_idx  output  INDICE_LEN  current beat's index
- out_pos  output  POS_W  position of the current beat in the array
- out_valid  output  1  beat available
- in_ready  input  1  downstream accepts the beat
- out_last  output  1  current beat is the final one of this snapshot
- out_busy  output  1  draining is in progress; snapshot requests are not accepted
- out_done  output  1  one-cycle pulse: the snapshot is fully drained
- out_overrun  output  1  one-cycle pulse: a snapshot request was dropped

## Operation
- FSM has two states: IDLE and SEND. out_busy = (state==SEND).
- IDLE, in_snapshot=1:
  - Register all entries of in_smallest_idx.
  - Register cnt = min(in_count, INDICES_COUNT).
  - Set pos=0.
  - If cnt≠0, go to SEND. If cnt==0, stay in IDLE and set out_done=1 for the next cycle.
- SEND:
  - out_valid=1.
  - out_idx = snap[pos].
  - out_pos = pos.
  - out_last = (pos==cnt-1).
  - Transfer occurs when out_valid && in_ready.
- Transfer on a non-last beat: pos ← pos+1.
- Transfer on the last beat: go to IDLE, pos ← 0, and out_done=1 for the next cycle.
- No transfer: out_idx, out_pos and out_last are held stable; beats are never skipped or duplicated.
- in_snapshot while in SEND (including the last-transfer cycle):
  - The request is ignored.
  - out_overrun=1 for the next cycle.
  - Captured data is unaffected.
- Changes on in_smallest_idx or in_count while in SEND have no effect; only the registered snapshot is streamed.
- out_idx=0, out_pos=0 and out_last=0 whenever out_valid=0.
- Output drive:
  - All outputs are driven from registers or from a mux on registered state/pos.
  - There is no combinational path from in_ready to out_valid.
  - Only the data path depends on pos.

## Timing
- Reset (async assert, any state): state=IDLE, pos=0, cnt=0, snapshot regs=0. Outputs: out_valid=0, out_idx=0, out_pos=0, out_last=0, out_busy=0, out_done=0, out_overrun=0.
- Reset release is synchronous to in_clk; the first snapshot is accepted on the first edge with in_rst_n=1.
- Reset asserted mid-stream aborts the stream immediately; there is no out_done for the aborted snapshot.
- Latency: snapshot sampled at edge T → out_valid=1 in cycle T+1 with pos 0.
- Throughput: 1 beat/cycle with in_ready held high. A snapshot of cnt entries drains in exactly cnt cycles.
- out_done is asserted in the cycle after the last-beat edge (or the cycle after the snapshot edge when cnt==0).
- A new snapshot is accepted in that same cycle (state is IDLE). The minimum gap between streams is 1 idle cycle.
- out_overrun and out_done are single-cycle pulses. They are asserted independently and may coincide.

## Test plan
(INDICES_COUNT=4, INDICE_LEN=8)
- Array {0x11,0x22,0x33,0x44}, count=4, snapshot, in_ready=1 → beats 0x11/0x22/0x33/0x44 with pos 0..3 on cycles T+1..T+4; out_last only with 0x44; out_done at T+5; out_busy high T+1..T+4.
- Same stimulus with in_ready pattern 1,0,0,1,1,0,1 → out_idx/out_pos held during stalls; sequence 0x11,0x22,0x33,0x44 with no gaps or duplicates; out_done the cycle after the 0x44 transfer.
- count=2 → beats 0x11, 0x22 (last on 0x22). count=0 → no out_valid, out_done at T+1. count=7 → clamped, 4 beats.
- Second snapshot at pos 1 with the array changed to {0xAA,...} → out_overrun pulse next cycle; stream continues 0x22,0x33,0x44 unchanged.
- Snapshot issued in the out_done cycle → accepted; next stream starts the following cycle; no out_overrun.
- in_rst_n low mid-cycle after 2 beats → out_valid/out_busy drop without waiting for an edge. After release, a new snapshot streams from pos 0 and no stale out_done appears.
